genius_sequencer: RTL



---
 rtl/genius_pkg.sv | 23 ++
 rtl/genius_timer.sv | 28 ++
 rtl/genius_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius sequence consumer: color type,
// controller state set and the color-to-LED decode.
package genius_pkg;

  localparam int NUM_COLORS = 4;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_PLAY_ON  = 3'd2,
    ST_PLAY_GAP = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  function automatic logic [NUM_COLORS-1:0] color_to_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/genius_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (value_reg != '0) begin
      value_reg <= value_reg - W'(1);
    end
  end

  assign value = value_reg;
  assign done  = (value_reg == '0);

endmodule

// File: rtl/genius_sequencer.sv
// Genius round controller: grows the color sequence, replays it on the LEDs and
// checks player presses. Define GENIUS_TIMEOUT_EN to lose after an idle entry window.
module genius_sequencer
  import genius_pkg::*;
#(
  parameter int MAX_LEN        = 32,
  parameter int ON_CYCLES      = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   rand_color,
  input  logic [3:0]                   btn,
  output logic [3:0]                   led,
  output logic                         input_ready,
  output logic                         busy,
  output logic                         win,
  output logic                         lose,
  output logic [$clog2(MAX_LEN+1)-1:0] level
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam int T_PLAY = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int T_MAX  = (T_PLAY > TIMEOUT_CYCLES) ? T_PLAY : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  // The timer counts down to zero inclusive, so each load is one less than the dwell.
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_APPEND   = ST_APPEND;
  localparam logic [2:0] S_PLAY_ON  = ST_PLAY_ON;
  localparam logic [2:0] S_PLAY_GAP = ST_PLAY_GAP;
  localparam logic [2:0] S_WAIT_IN  = ST_WAIT_IN;
  localparam logic [2:0] S_WIN      = ST_WIN;
  localparam logic [2:0] S_LOSE     = ST_LOSE;

  logic [2:0]       state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  color_t mem [MAX_LEN];
  logic   mem_we;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_value;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_done;
  logic             unused_tmr;

  logic [NUM_COLORS-1:0] expected_btn;
  logic                  at_last;
  logic                  len_full;

  genius_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_value(tmr_load_value),
    .value     (tmr_value),
    .done      (tmr_done)
  );

  // Only the done flag steers the FSM; the raw count is kept for observability.
  assign unused_tmr = ^tmr_value;

  assign expected_btn = color_to_onehot(mem[idx_reg]);
  assign at_last      = (LEN_W'(idx_reg) == len_reg - LEN_W'(1));
  assign len_full     = (len_reg == LEN_W'(MAX_LEN));

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    mem_we         = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;

    if (start) begin
      state_next = S_APPEND;
      len_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        S_APPEND: begin
          mem_we         = 1'b1;
          len_next       = len_reg + LEN_W'(1);
          idx_next       = '0;
          tmr_load       = 1'b1;
          tmr_load_value = ON_LOAD;
          state_next     = S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (tmr_done) begin
            tmr_load       = 1'b1;
            tmr_load_value = GAP_LOAD;
            state_next     = S_PLAY_GAP;
          end
        end
        S_PLAY_GAP: begin
          if (tmr_done) begin
            if (at_last) begin
              idx_next   = '0;
              state_next = S_WAIT_IN;
`ifdef GENIUS_TIMEOUT_EN
              tmr_load       = 1'b1;
              tmr_load_value = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
            end else begin
              idx_next       = idx_reg + IDX_W'(1);
              tmr_load       = 1'b1;
              tmr_load_value = ON_LOAD;
              state_next     = S_PLAY_ON;
            end
          end
        end
        S_WAIT_IN: begin
          // A multi-hot press can never equal a one-hot expectation, so it loses too.
          if (btn != '0) begin
            if (btn != expected_btn) begin
              state_next = S_LOSE;
            end else if (at_last) begin
              state_next = len_full ? S_WIN : S_APPEND;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
`ifdef GENIUS_TIMEOUT_EN
              tmr_load       = 1'b1;
              tmr_load_value = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
`ifdef GENIUS_TIMEOUT_EN
          else if (tmr_done) begin
            state_next = S_LOSE;
          end
`endif
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
    end
  end

  // Entries at or beyond len are never read, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_reg[IDX_W-1:0]] <= rand_color;
    end
  end

  assign led         = (state_reg == S_PLAY_ON) ? expected_btn : 4'b0000;
  assign input_ready = (state_reg == S_WAIT_IN);
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_WIN) && (state_reg != S_LOSE);
  assign win         = (state_reg == S_WIN);
  assign lose        = (state_reg == S_LOSE);
  assign level       = len_reg;

endmodule
